// File: rtl/dice_roll_arbiter.sv
// dice_roll_arbiter: round-robin sequencer that shares one dice roller among
// NUM_REQ players. It latches the winner's die selection, fires one roll, waits
// for the roller's answer (or gives up after TIMEOUT cycles), range-checks it
// and hands it back with a one-cycle acknowledge.
module dice_roll_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_die,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           result,
    output logic                 error,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 roll_out,
    output logic [1:0]           die_out,
    input  logic                 roll_done,
    input  logic [7:0]           roll_value
);

    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [7:0]           timer_q, timer_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [7:0]           result_q, result_d;
    logic                 error_q, error_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;
    logic                 roll_out_q, roll_out_d;
    logic [1:0]           die_q, die_d;

    logic                 win_found;
    logic [IDW-1:0]       win_id;
    logic [1:0]           win_die;
    logic [SW-1:0]        cand_sum;

    // Number of faces for a die select code.
    function automatic logic [7:0] die_sides(input logic [1:0] sel);
        case (sel)
            2'b00:   return 8'd4;
            2'b01:   return 8'd6;
            2'b10:   return 8'd8;
            default: return 8'd20;
        endcase
    endfunction

    // A legal roll lies in 1..sides of the selected die.
    function automatic logic roll_in_range(input logic [1:0] sel, input logic [7:0] value);
        return (value != 8'd0) && (value <= die_sides(sel));
    endfunction

    // One-hot acknowledge vector for a player index.
    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (id == IDW'(i));
        end
        return v;
    endfunction

    // Round-robin search: first requesting player at or above ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_die   = 2'b00;
        cand_sum  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, ptr_q} + SW'(i);
            if (cand_sum >= SW'(NUM_REQ)) begin
                cand_sum = cand_sum - SW'(NUM_REQ);
            end
            if (!win_found && req[cand_sum[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand_sum[IDW-1:0];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_id == IDW'(j)) begin
                win_die = req_die[2*j +: 2];
            end
        end
    end

    // Sequencer next-state and next-output logic; every output is registered.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        grant_id_d = grant_id_q;
        die_d      = die_q;
        ack_d      = '0;
        result_d   = 8'd0;
        error_d    = 1'b0;
        roll_out_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_id_d = win_id;
                    die_d      = win_die;
                    roll_out_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A reply on the expiry cycle still counts as a real roll.
                if (roll_done) begin
                    result_d = roll_value;
                    error_d  = !roll_in_range(die_q, roll_value);
                    ack_d    = one_hot(grant_id_q);
                    state_d  = S_DELIVER;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    result_d = 8'd0;
                    error_d  = 1'b1;
                    ack_d    = one_hot(grant_id_q);
                    state_d  = S_DELIVER;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                if (grant_id_q == IDW'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_id_q + IDW'(1);
                end
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any roll in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            timer_q    <= 8'd0;
            ack_q      <= '0;
            result_q   <= 8'd0;
            error_q    <= 1'b0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            roll_out_q <= 1'b0;
            die_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            ack_q      <= ack_d;
            result_q   <= result_d;
            error_q    <= error_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            roll_out_q <= roll_out_d;
            die_q      <= die_d;
        end
    end

    assign ack      = ack_q;
    assign result   = result_q;
    assign error    = error_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign roll_out = roll_out_q;
    assign die_out  = die_q;

endmodule

// File: doc/dice_roll_arbiter.md
# dice_roll_arbiter

Round-robin arbiter and sequencer that shares one dice-roller datapath among `NUM_REQ` players. It holds each player's request and die selection, issues a single roll to the shared roller and waits for its result. It range-checks the result against the selected die, then returns it to the winning player with a one-cycle acknowledge. It sits between the player/game-logic ports and the roller, and supervises a non-responding roller with a timeout.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; must be 2..8.
- `TIMEOUT`, 15: cycles spent in WAIT before the roll is abandoned; must be 1..255.
- `IDW`, `$clog2(NUM_REQ)`: derived width of the grant id.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  level request per player; held high until that player's `ack`.
- `req_die`  in  2*NUM_REQ  die select for player i in bits [2i+1:2i]: 00=d4, 01=d6, 10=d8, 11=d20.
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `result`  out  8  rolled value; valid only while `ack` is non-zero.
- `error`  out  1  high with `ack` when the roll timed out or was out of range.
- `grant_id`  out  IDW  index of the player currently being served.
- `busy`  out  1  high in every state except IDLE.
- `roll_out`  out  1  one-cycle roll pulse to the roller.
- `die_out`  out  2  die select to the roller; stable from ISSUE through DELIVER.
- `roll_done`  in  1  roller pulse marking `roll_value` valid.
- `roll_value`  in  8  roller result.

## Operation
- State machine: IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
- IDLE:
  - If any `req` is high, grant the first set bit searching upward from `ptr`, wrapping modulo `NUM_REQ`.
  - Register `grant_id` and `die_out` from the winner's `req_die` slice, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: `roll_out`=1 for exactly this cycle; clear `timer`; go to WAIT.
- WAIT (`roll_done` high):
  - Capture `roll_value` and go to DELIVER.
  - `error` is set if the value is outside 1..sides (sides 4/6/8/20 per `die_out`); `result` still carries the raw value.
- WAIT (no `roll_done`):
  - `timer` increments.
  - When `timer`==`TIMEOUT`-1 and `roll_done` is still low, go to DELIVER with `result`=0 and `error`=1.
  - `roll_done` on the same cycle as expiry wins: the value is taken.
- DELIVER:
  - Drive `ack[grant_id]`=1 along with `result` and `error`.
  - Set `ptr` <= (`grant_id`+1) mod `NUM_REQ`, then go to IDLE.
- `ptr` reset value is 0. `ack`, `result` and `error` are 0 outside DELIVER.
- A requester drops `req` in the cycle after its `ack`. The arbiter re-samples `req` in the following IDLE cycle, so a player that keeps `req` high is served again only after every other pending player.
- `roll_done` outside WAIT is ignored.
- `req_die` changes after the grant are ignored; the die is latched in IDLE.
- A `req` deasserted mid-roll is not honoured: the roll completes and is acked anyway.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `ptr`=0, `timer`=0, and all outputs 0 (`ack`, `result`, `error`, `grant_id`, `busy`, `roll_out`, `die_out`).
- Reset asserted mid-operation aborts immediately. The roller is not notified; a late `roll_done` arriving after reset is ignored because state is IDLE.
- Let `req` be high in IDLE at cycle 0:
  - `busy`=1 and `roll_out`=1 in cycle 1.
  - `roll_done` is first accepted in cycle 2.
  - `roll_done` in cycle k gives `ack` in cycle k+1.
  - Minimum req-to-ack latency is 3 cycles.
- Timeout: with no `roll_done`, `ack` with `error` arrives in cycle `TIMEOUT`+2.
- Back-to-back throughput: one roll per 4 cycles at best, because IDLE lasts one cycle between grants.

## Test plan
- Single player: player 2 `req`, die 01; roller returns 5 two cycles after `roll_out` -> `ack`=0100, `result`=5, `error`=0; `die_out`=01.
- Round robin: players 0, 1 and 3 hold `req` continuously; roller returns immediately -> grant order 0, 1, 3, 0, 1, 3, with exactly one `roll_out` per grant.
- Range check: d4 selected, roller returns 7, then 0 -> both acked with `error`=1 and `result`=7 and 0 respectively. d20 with 20 -> `error`=0.
- Timeout: `TIMEOUT`=15, roller silent -> `ack` with `result`=0 and `error`=1 in cycle 17 after `req`. A `roll_done` arriving in cycle 20 is ignored.
- Boundary: `roll_done` lands exactly on the last WAIT cycle -> value delivered and `error`=0. `roll_done` pulsed during IDLE -> no effect.
- Reset mid-WAIT: assert `reset` low -> all outputs 0 at once. After release, the pending request from player 0 is re-granted first (`ptr`=0).
